tile_blitter: RTL and testbench
===============================

// Module: tile_blitter
// PURPOSE
//  Parametrised tile renderer: on a draw request, walks a TILE_W x TILE_H tile and reads each pixel from an external tile ROM.
//  Emits one plot strobe per visible pixel to the VGA frame-buffer writer.
//  Adds over the fixed 8x8 drawer: a tile index, a screen origin, per-pixel colour and screen-edge clipping.
// PARAMETERS
//  TILE_W     8    tile width in pixels; power of two, >=2
//  TILE_H     8    tile height in pixels; power of two, >=2
//  TILE_ID_W  4    tile index width (2**TILE_ID_W tiles in ROM)
//  X_W        8    screen x coordinate width
//  Y_W        7    screen y coordinate width
//  SCREEN_W   160  visible width; pixels with x >= SCREEN_W are clipped
//  SCREEN_H   120  visible height; pixels with y >= SCREEN_H are clipped
//  COLOR_W    3    pixel colour width
//  KEY_COLOR  0    transparent colour value (used only with TRANSPARENCY_EN)
// PORTS
//  clock      in   1          system clock, rising edge
//  resetn     in   1          asynchronous, active-low reset
//  draw       in   1          request; sampled only in IDLE
//  tile_id    in   TILE_ID_W  tile to draw; latched when draw is accepted
//  origin_x   in   X_W        top-left x; latched when draw is accepted
//  origin_y   in   Y_W        top-left y; latched when draw is accepted
//  rom_addr   out  TILE_ID_W+log2(TILE_W*TILE_H)  = {tile_id, cy, cx}
//  rom_data   in   COLOR_W    ROM output; valid 1 cycle after rom_addr (synchronous ROM)
//  plot       out  1          write strobe to frame buffer
//  plot_x     out  X_W        origin_x + cx, truncated
//  plot_y     out  Y_W        origin_y + cy, truncated
//  plot_color out  COLOR_W    = rom_data during PLOT
//  busy       out  1          high in FETCH and PLOT
//  drawDone   out  1          one-cycle pulse in DONE
// BEHAVIOUR
//  - States: IDLE, FETCH, PLOT, DONE.
//    - IDLE -(draw)-> FETCH.
//    - FETCH -> PLOT.
//    - PLOT -> DONE when cx==TILE_W-1 and cy==TILE_H-1; otherwise -> FETCH with the counters advanced.
//    - DONE -> IDLE.
//  - Counters:
//    - cx/cy clear on draw accept.
//    - cx increments on PLOT->FETCH. At TILE_W-1, cx wraps to 0 and cy increments.
//  - Reset: state=IDLE, counters=0, latched regs=0. plot=0, busy=0, drawDone=0, rom_addr=0 immediately (async).
//  - Timing: 2 cycles per pixel. Draw accepted at edge N gives:
//    - first PLOT cycle after edge N+2;
//    - DONE after edge N+2*TILE_W*TILE_H+1 (129 cycles for 8x8).
//  - rom_addr is driven from the latched tile_id and the counters. It is stable in both FETCH and PLOT.
//  - Clipping:
//    - Sums are computed at X_W+1 / Y_W+1 bits.
//    - plot=0 if sum_x >= SCREEN_W or sum_y >= SCREEN_H, including carry-out.
//    - The walk still takes full time: no early exit.
//  - plot, plot_x, plot_y and plot_color are meaningful only in PLOT. plot=0 in all other states.
//  - draw while busy or in DONE is ignored; no queueing. A draw held high re-triggers in the first IDLE cycle after DONE.
//  - Reset mid-draw aborts with no drawDone pulse. Inputs may change freely after acceptance.
// CONFIGURATION
//  TRANSPARENCY_EN defined:
//    - in PLOT, rom_data==KEY_COLOR forces plot=0;
//    - timing is unchanged.
//  TRANSPARENCY_EN undefined:
//    - every in-bounds pixel is plotted, KEY_COLOR included;
//    - KEY_COLOR is unused.
// STRUCTURE
//  - tile_gfx_pkg (shared with the other sprite/tile blocks) holds:
//    - state encoding constants (IDLE=2'b00, FETCH=2'b01, PLOT=2'b10, DONE=2'b11);
//    - default TILE_W/TILE_H/SCREEN_W/SCREEN_H/COLOR_W;
//    - a clog2 function.
//  - Sub-module tile_xy_counter (params W,H): clear, step, cx, cy, last.
//    - Holds the 2-D walk.
//    - Reused by the planned sprite blitter.
//  - FSM, clip logic and address concatenation live in tile_blitter.
// TESTING
//  1. Reset, then draw tile_id=3 at (10,20), 8x8, ROM pattern colour=(cx+cy)&7:
//     - exactly 64 plots;
//     - first is (10,20) c=0, last is (17,27) c=6;
//     - drawDone once, 129 cycles after accept;
//     - rom_addr = {4'd3, cy, cx}.
//  2. origin (156,116): only 16 plots, for x 156..159 and y 116..119; drawDone still at 129 cycles.
//  3. origin (250,0) with X_W=8: sums overflow the 8-bit field but are compared at 9 bits, so all pixels clip. 0 plots, drawDone pulses.
//  4. Pulse draw during busy at pixel 20 -> ignored; exactly one drawDone. Hold draw high -> second draw starts the cycle after DONE.
//  5. Assert resetn=0 mid-draw -> plot/busy drop at once with no drawDone. After release, a new draw completes normally.
//  6. TRANSPARENCY_EN, KEY_COLOR=0, checkerboard ROM -> 32 plots. Without the macro -> 64 plots.

Source files
------------

// File: rtl/tile_gfx_pkg.sv
`default_nettype none
// tile_gfx_pkg: shared definitions for the tile/sprite rendering blocks.
// Rev 1.0 - walk-state encoding, default geometry, clog2 helper.

package tile_gfx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_PLOT  = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  localparam int DEF_TILE_W   = 8;
  localparam int DEF_TILE_H   = 8;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;
  localparam int DEF_COLOR_W  = 3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tile_blitter_if.sv
`default_nettype none
// tile_blitter_if: draw request, tile ROM and frame-buffer plot signals.
// Rev 1.0 - master = host/ROM side, slave = blitter side.

interface tile_blitter_if import tile_gfx_pkg::*; #(
  parameter int TILE_W    = DEF_TILE_W,
  parameter int TILE_H    = DEF_TILE_H,
  parameter int TILE_ID_W = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int COLOR_W   = DEF_COLOR_W
) ();

  localparam int ADDR_W = TILE_ID_W + clog2(TILE_W * TILE_H);

  logic                 draw;
  logic [TILE_ID_W-1:0] tile_id;
  logic [X_W-1:0]       origin_x;
  logic [Y_W-1:0]       origin_y;
  logic [ADDR_W-1:0]    rom_addr;
  logic [COLOR_W-1:0]   rom_data;
  logic                 plot;
  logic [X_W-1:0]       plot_x;
  logic [Y_W-1:0]       plot_y;
  logic [COLOR_W-1:0]   plot_color;
  logic                 busy;
  logic                 drawDone;

  modport master (
    output draw, tile_id, origin_x, origin_y, rom_data,
    input  rom_addr, plot, plot_x, plot_y, plot_color, busy, drawDone
  );

  modport slave (
    input  draw, tile_id, origin_x, origin_y, rom_data,
    output rom_addr, plot, plot_x, plot_y, plot_color, busy, drawDone
  );

endinterface

`default_nettype wire

// File: rtl/tile_xy_counter.sv
`default_nettype none
// tile_xy_counter: 2-D raster walk over a W x H block, cx fastest.
// Rev 1.0 - clear has priority over step; last flags the final cell.

module tile_xy_counter import tile_gfx_pkg::*; #(
  parameter int W = DEF_TILE_W,
  parameter int H = DEF_TILE_H
) (
  input  wire logic                clock,
  input  wire logic                resetn,
  input  wire logic                clear_i,
  input  wire logic                step_i,
  output logic [clog2(W)-1:0]      cx_o,
  output logic [clog2(H)-1:0]      cy_o,
  output logic                     last_o
);

  localparam int CX_W = clog2(W);
  localparam int CY_W = clog2(H);

  logic [CX_W-1:0] cx_q, cx_d;
  logic [CY_W-1:0] cy_q, cy_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (step_i) begin
      if (cx_q == CX_W'(W - 1)) begin
        cx_d = '0;
        cy_d = (cy_q == CY_W'(H - 1)) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_o   = cx_q;
  assign cy_o   = cy_q;
  assign last_o = (cx_q == CX_W'(W - 1)) && (cy_q == CY_W'(H - 1));

endmodule

`default_nettype wire

// File: rtl/tile_blitter.sv
`default_nettype none
// tile_blitter: walks a tile from a synchronous ROM and plots it with screen-edge clipping.
// Rev 1.0 - optional colour-key transparency under `TRANSPARENCY_EN.

module tile_blitter import tile_gfx_pkg::*; #(
  parameter int TILE_W    = DEF_TILE_W,
  parameter int TILE_H    = DEF_TILE_H,
  parameter int TILE_ID_W = 4,
  parameter int X_W       = 8,
  parameter int Y_W       = 7,
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int COLOR_W   = DEF_COLOR_W,
  parameter int KEY_COLOR = 0
) (
  input  wire logic      clock,
  input  wire logic      resetn,
  tile_blitter_if.slave  bus
);

  localparam int CX_W = clog2(TILE_W);
  localparam int CY_W = clog2(TILE_H);

  state_e               state_q;
  logic [TILE_ID_W-1:0] tile_q;
  logic [X_W-1:0]       ox_q;
  logic [Y_W-1:0]       oy_q;
  logic                 plot_q;
  logic                 busy_q;
  logic                 done_q;

  logic [CX_W-1:0]      cx;
  logic [CY_W-1:0]      cy;
  logic                 last;
  logic                 clear;
  logic                 step;
  logic [X_W:0]         sum_x;
  logic [Y_W:0]         sum_y;
  logic                 in_bounds;
  logic                 key_hit;

  assign clear = (state_q == ST_IDLE) && bus.draw;
  assign step  = (state_q == ST_PLOT) && !last;

  tile_xy_counter #(
    .W (TILE_W),
    .H (TILE_H)
  ) u_xy (
    .clock   (clock),
    .resetn  (resetn),
    .clear_i (clear),
    .step_i  (step),
    .cx_o    (cx),
    .cy_o    (cy),
    .last_o  (last)
  );

  // One extra bit keeps the carry so wrapped coordinates still clip.
  assign sum_x     = (X_W+1)'(ox_q) + (X_W+1)'(cx);
  assign sum_y     = (Y_W+1)'(oy_q) + (Y_W+1)'(cy);
  assign in_bounds = (sum_x < (X_W+1)'(SCREEN_W)) && (sum_y < (Y_W+1)'(SCREEN_H));

`ifdef TRANSPARENCY_EN
  assign key_hit = (bus.rom_data == COLOR_W'(KEY_COLOR));
`else
  logic [COLOR_W-1:0] key_unused;
  assign key_unused = COLOR_W'(KEY_COLOR);
  assign key_hit    = 1'b0;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      tile_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      plot_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.draw) begin
            tile_q  <= bus.tile_id;
            ox_q    <= bus.origin_x;
            oy_q    <= bus.origin_y;
            busy_q  <= 1'b1;
            state_q <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          // The clip decision is known a cycle early; ROM data lands with PLOT.
          plot_q  <= in_bounds;
          state_q <= ST_PLOT;
        end
        ST_PLOT: begin
          plot_q <= 1'b0;
          if (last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_FETCH;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_addr   = {tile_q, cy, cx};
  assign bus.plot       = plot_q & ~key_hit;
  assign bus.plot_x     = sum_x[X_W-1:0];
  assign bus.plot_y     = sum_y[Y_W-1:0];
  assign bus.plot_color = bus.rom_data;
  assign bus.busy       = busy_q;
  assign bus.drawDone   = done_q;

endmodule

`default_nettype wire

// File: tb/tb_tile_blitter.sv
`default_nettype none
// tb_tile_blitter: scoreboard bench for tile_blitter (8x8 tiles, 160x120 screen).
// Rev 1.0 - honours `TRANSPARENCY_EN for the colour-key case.

module tb_tile_blitter;

  logic clock;
  logic resetn;

  tile_blitter_if bus ();

  tile_blitter dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic [9:0] a;
  } pix_t;

  pix_t exp_q[$];
  int   lat_q[$];
  pix_t exp_e;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int acc_edge = 0;
  int done_cnt = 0;
  int plot_cnt = 0;
  int rom_pat = 0;
  bit first_pend = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] rom_color(input int cx, input int cy);
    if (rom_pat == 0) return 3'((cx + cy) & 7);
    return ((cx + cy) & 1) ? 3'd5 : 3'd0;
  endfunction

  // Synchronous tile ROM: address {id, cy, cx}, data one cycle later.
  always @(posedge clock) bus.rom_data <= rom_color(int'(bus.rom_addr[2:0]), int'(bus.rom_addr[5:3]));

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  always @(negedge clock) begin
    if (resetn) begin
      if (bus.plot) begin
        plot_cnt++;
        if (first_pend) begin
          check("first_plot_latency", edge_cnt - acc_edge + 1, 2);
          first_pend = 1'b0;
        end
        if (exp_q.size() == 0) begin
          check("plot_unexpected", bus.plot, 1'b0);
        end else begin
          exp_e = exp_q.pop_front();
          check("plot_x", bus.plot_x, exp_e.x);
          check("plot_y", bus.plot_y, exp_e.y);
          check("plot_color", bus.plot_color, exp_e.c);
          check("rom_addr", bus.rom_addr, exp_e.a);
          check("busy_in_plot", bus.busy, 1'b1);
        end
      end
      if (bus.drawDone) begin
        done_cnt++;
        if (lat_q.size() == 0) check("done_unexpected", bus.drawDone, 1'b0);
        else check("done_latency", edge_cnt - acc_edge + 1, lat_q.pop_front());
      end
    end
  end

  task automatic push_draw(input int id, input int ox, input int oy);
    pix_t p;
    bit   vis;
    for (int cy = 0; cy < 8; cy++) begin
      for (int cx = 0; cx < 8; cx++) begin
        p.c = rom_color(cx, cy);
        vis = ((ox + cx) < 160) && ((oy + cy) < 120);
`ifdef TRANSPARENCY_EN
        if (p.c == 3'd0) vis = 1'b0;
`endif
        if (vis) begin
          p.x = 8'(ox + cx);
          p.y = 7'(oy + cy);
          p.a = 10'(id * 64 + cy * 8 + cx);
          exp_q.push_back(p);
        end
      end
    end
  endtask

  task automatic start_draw(input int id, input int ox, input int oy);
    @(negedge clock);
    bus.draw     = 1'b1;
    bus.tile_id  = 4'(id);
    bus.origin_x = 8'(ox);
    bus.origin_y = 7'(oy);
    acc_edge     = edge_cnt + 1;
    plot_cnt     = 0;
    lat_q.push_back(129);
    push_draw(id, ox, oy);
    @(negedge clock);
    bus.draw     = 1'b0;
    bus.tile_id  = 4'($urandom);
    bus.origin_x = 8'($urandom);
    bus.origin_y = 7'($urandom);
  endtask

  task automatic wait_done(input int tgt);
    for (int i = 0; i < 600 && done_cnt < tgt; i++) @(negedge clock);
    check("done_count", done_cnt, tgt);
  endtask

  task automatic run_draw(input int id, input int ox, input int oy, input int n_exp, input string tag);
    int tgt;
    tgt = done_cnt + 1;
    start_draw(id, ox, oy);
    wait_done(tgt);
    check(tag, plot_cnt, n_exp);
    check("scoreboard_empty", exp_q.size(), 0);
  endtask

  initial begin
    int tgt;
    int saved;
    resetn       = 1'b0;
    bus.draw     = 1'b0;
    bus.tile_id  = '0;
    bus.origin_x = '0;
    bus.origin_y = '0;
    repeat (2) @(negedge clock);
    check("reset_plot", bus.plot, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.drawDone, 1'b0);
    check("reset_rom_addr", bus.rom_addr, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clock);

    first_pend = 1'b1;
    run_draw(3, 10, 20, 64, "t1_plot_count");
    run_draw(7, 156, 116, 16, "t2_plot_count");
    run_draw(1, 250, 0, 0, "t3_plot_count");

    // Extra draw pulse in the middle of pixel 20 must be ignored.
    tgt = done_cnt + 1;
    start_draw(2, 40, 40);
    repeat (40) @(negedge clock);
    bus.draw = 1'b1;
    @(negedge clock);
    bus.draw = 1'b0;
    wait_done(tgt);
    repeat (20) @(negedge clock);
    check("t4_single_done", done_cnt, tgt);
    check("t4_idle_busy", bus.busy, 1'b0);
    check("scoreboard_empty", exp_q.size(), 0);

    // Held draw re-triggers in the IDLE cycle right after DONE.
    tgt = done_cnt + 2;
    @(negedge clock);
    bus.draw     = 1'b1;
    bus.tile_id  = 4'd4;
    bus.origin_x = 8'd0;
    bus.origin_y = 7'd0;
    acc_edge     = edge_cnt + 1;
    plot_cnt     = 0;
    lat_q.push_back(129);
    lat_q.push_back(259);
    push_draw(4, 0, 0);
    push_draw(4, 0, 0);
    repeat (131) @(negedge clock);
    bus.draw = 1'b0;
    wait_done(tgt);
    check("t4_hold_plot_count", plot_cnt, 128);
    check("scoreboard_empty", exp_q.size(), 0);

    // Asynchronous reset in the middle of a PLOT cycle.
    start_draw(3, 10, 20);
    repeat (31) @(negedge clock);
    check("t5_plot_before_reset", bus.plot, 1'b1);
    #1 resetn = 1'b0;
    #1;
    check("t5_plot_async", bus.plot, 1'b0);
    check("t5_busy_async", bus.busy, 1'b0);
    check("t5_done_async", bus.drawDone, 1'b0);
    check("t5_rom_addr_async", bus.rom_addr, 0);
    exp_q.delete();
    lat_q.delete();
    saved = done_cnt;
    repeat (3) @(negedge clock);
    resetn = 1'b1;
    repeat (150) @(negedge clock);
    check("t5_no_done", done_cnt, saved);
    run_draw(9, 0, 0, 64, "t5_after_reset_count");

    rom_pat = 1;
`ifdef TRANSPARENCY_EN
    run_draw(5, 0, 0, 32, "t6_key_plot_count");
`else
    run_draw(5, 0, 0, 64, "t6_key_plot_count");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
